bg_affine_coord_engine: RTL and testbench
=========================================

Name: bg_affine_coord_engine

Overview:
- Parametrised successor to the fixed two-background rotation/scaling path in the background pipeline.
- Holds per-channel affine reference points and per-pixel accumulators for NUM_CH affine backgrounds, time-multiplexed on one adder pair.
- Each pixel request for one channel returns integer texture coordinates plus an out-of-map flag one cycle later.
- Adds behaviour the old path lacks:
  - mid-frame reference-point reload on register write;
  - per-channel wrap/clip by map size;
  - an optional mosaic hold.

Parameters:
- NUM_CH, 2, number of affine background channels (1..4).
- COORD_W, 28, width of signed 20.8 reference/accumulator registers.
- FRAC_BITS, 8, fractional bits in coordinates and pa..pd.
- OUT_W, 10, width of integer coordinate outputs.

Ports:
- clock  in  1  system clock.
- rst_b  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse before visible line 0.
- row_start  in  1  one-cycle pulse before each visible line 1..159.
- ref_x  in  NUM_CH*COORD_W  per-channel BGxX register values, channel 0 in LSBs.
- ref_y  in  NUM_CH*COORD_W  per-channel BGxY register values.
- ref_wr  in  NUM_CH  pulse: CPU wrote X or Y of that channel.
- pa, pb, pc, pd  in  NUM_CH*16 each  signed 8.8 dx, dmx, dy, dmy.
- map_size  in  NUM_CH*2  size code; map edge = 128 << code pixels.
- wrap_en  in  NUM_CH  1 = wrap, 0 = clip.
- pix_req  in  1  request one pixel for channel pix_ch.
- pix_ch  in  $clog2(NUM_CH) (min 1)  channel select.
- out_valid  out  1  registered, high one cycle after pix_req.
- out_ch  out  $clog2(NUM_CH)  channel of the output.
- out_x, out_y  out  OUT_W each  integer texture coordinates.
- out_ovf  out  1  pixel outside map with clip selected; treat as transparent.

Behaviour:
- State per channel c: int_x/int_y (row reference), cur_x/cur_y (accumulator), pend (reload pending).
- Reset values:
  - all state and all outputs are 0;
  - pend = 0.
- Event priority per cycle: reset > frame_start > row_start > pix_req. ref_wr is recorded in every cycle.
- frame_start, all c:
  - int_x, cur_x <= ref_x[c]; int_y, cur_y <= ref_y[c];
  - pend <= 0. A ref_wr in the same cycle is absorbed.
- row_start, all c:
  - if pend: int <= ref register value;
  - else: int_x <= int_x + sext(pb); int_y <= int_y + sext(pd);
  - cur <= the new int value; pend <= 0;
  - a ref_wr in the same cycle sets pend for the next row.
- ref_wr[c] outside frame_start: pend[c] <= 1. Current-line accumulation is unaffected.
- pix_req, channel c:
  - register output from cur_x/cur_y as they are before the update;
  - then cur_x += sext(pa); cur_y += sext(pc);
  - row_start or frame_start in the same cycle overrides the accumulator update, but the output is still produced.
- Arithmetic:
  - two's complement, modulo 2^COORD_W;
  - integer part = bits [COORD_W-1:FRAC_BITS], signed.
- Map check, size S = 128 << map_size:
  - wrap_en = 1: out = integer part mod S (low bits masked); out_ovf = 0.
  - wrap_en = 0: out_ovf = 1 if integer part < 0 or >= S; out_x/out_y carry the low OUT_W bits regardless.
- Timing:
  - latency exactly 1 cycle; throughput 1 request per cycle;
  - back-to-back requests to the same channel use the stepped value.
- pix_ch >= NUM_CH: request ignored, out_valid = 0.
- Reset asserted mid-line: everything clears immediately. The first frame_start restores the state.

Optional Feature:
- Macro: BG_AFFINE_MOSAIC_EN. With it, extra inputs mos_h[3:0] and mos_v[3:0] (MOSAIC register fields) are added.
  - Horizontal: per-channel hold counter hc. The output coordinate is captured when hc == 0; subsequent requests return the captured value. hc wraps after mos_h. The accumulator still steps every request. hc clears on row_start and frame_start.
  - Vertical: per-channel line counter vc. On row_start, cur reloads from int only when vc wraps to 0; otherwise cur reloads from a saved mosaic row base. vc clears on frame_start.
  - mos_h = mos_v = 0 gives identical behaviour to the feature-absent build.
- Without the macro: ports absent, no hold logic.

Test Plan:
- Identity map: ref_x = ref_y = 0, pa = 0x0100, pc = 0, frame_start, 4 pix_req ch0 -> out_x = 0, 1, 2, 3; out_y = 0; out_valid 1 cycle after each request.
- Row step: pb = 0, pd = 0x0100, two row_start pulses -> next pix_req returns out_y = 2.
- Clip vs wrap: ref_x = 0x0007F00 (127.0), size 0, pa = 0x0100 -> second request:
  - wrap_en = 0: out_ovf = 1;
  - wrap_en = 1: out_x = 0, out_ovf = 0.
- Mid-frame reload: ref_wr[1] with ref_y = 0x0005000 mid-line.
  - Current-line outputs are unchanged.
  - After the next row_start, ch1 out_y = 80, ignoring pd.
- Simultaneous events: frame_start together with row_start and pix_req.
  - Output reflects the old cur.
  - Next request returns ref values.
- Mosaic (macro on): mos_h = 2, pa = 0x0100 -> out_x = 0, 0, 0, 3, 3, 3; with mos_h = 0, out_x = 0, 1, 2.

Source files
------------

// File: rtl/bg_affine_coord_engine.sv
// Affine background texture coordinate engine, NUM_CH channels on one adder pair.
// Optional mosaic hold is built when BG_AFFINE_MOSAIC_EN is defined.
module bg_affine_coord_engine #(
    parameter  int NUM_CH    = 2,
    parameter  int COORD_W   = 28,
    parameter  int FRAC_BITS = 8,
    parameter  int OUT_W     = 10,
    localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      rst_b,
    input  logic                      frame_start,
    input  logic                      row_start,
    input  logic [NUM_CH*COORD_W-1:0] ref_x,
    input  logic [NUM_CH*COORD_W-1:0] ref_y,
    input  logic [NUM_CH-1:0]         ref_wr,
    input  logic [NUM_CH*16-1:0]      pa,
    input  logic [NUM_CH*16-1:0]      pb,
    input  logic [NUM_CH*16-1:0]      pc,
    input  logic [NUM_CH*16-1:0]      pd,
    input  logic [NUM_CH*2-1:0]       map_size,
    input  logic [NUM_CH-1:0]         wrap_en,
`ifdef BG_AFFINE_MOSAIC_EN
    input  logic [3:0]                mos_h,
    input  logic [3:0]                mos_v,
`endif
    input  logic                      pix_req,
    input  logic [CHW-1:0]            pix_ch,
    output logic                      out_valid,
    output logic [CHW-1:0]            out_ch,
    output logic [OUT_W-1:0]          out_x,
    output logic [OUT_W-1:0]          out_y,
    output logic                      out_ovf
);

    localparam int IW = COORD_W - FRAC_BITS;

    typedef logic [COORD_W-1:0] coord_t;

    coord_t            int_x [NUM_CH];
    coord_t            int_y [NUM_CH];
    coord_t            cur_x [NUM_CH];
    coord_t            cur_y [NUM_CH];
    logic [NUM_CH-1:0] pend;

    coord_t            nxt_x [NUM_CH];
    coord_t            nxt_y [NUM_CH];
    coord_t            rld_x [NUM_CH];
    coord_t            rld_y [NUM_CH];

    logic              hit;
    logic [CHW-1:0]    sel;
    logic [OUT_W:0]    mx;
    logic [OUT_W:0]    my;
    logic [OUT_W-1:0]  res_x;
    logic [OUT_W-1:0]  res_y;
    logic              res_ovf;

`ifdef BG_AFFINE_MOSAIC_EN
    logic [3:0]        hc [NUM_CH];
    logic [3:0]        vc [NUM_CH];
    logic [3:0]        vc_nxt [NUM_CH];
    coord_t            base_x [NUM_CH];
    coord_t            base_y [NUM_CH];
    logic [OUT_W-1:0]  hold_x [NUM_CH];
    logic [OUT_W-1:0]  hold_y [NUM_CH];
    logic              hold_ovf [NUM_CH];
`endif

    function automatic coord_t sext16(input logic [15:0] v);
        return {{(COORD_W-16){v[15]}}, v};
    endfunction

    // Integer part against map edge: wrap masks, clip flags out-of-range.
    function automatic logic [OUT_W:0] map_coord(
        input coord_t     v,
        input logic [1:0] code,
        input logic       wrap
    );
        logic [IW-1:0] ip;
        logic [IW-1:0] sz;
        logic          ovf;
        ip  = v[COORD_W-1:FRAC_BITS];
        sz  = IW'(128) << code;
        ovf = ip[IW-1] || (ip >= sz);
        if (wrap) begin
            ip  = ip & (sz - IW'(1));
            ovf = 1'b0;
        end
        return {ovf, ip[OUT_W-1:0]};
    endfunction

    // Decode the request and form the coordinate seen before this step.
    always_comb begin
        hit     = 1'b0;
        sel     = '0;
        mx      = '0;
        my      = '0;
        res_x   = '0;
        res_y   = '0;
        res_ovf = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pix_req && pix_ch == CHW'(c)) begin
                hit     = 1'b1;
                sel     = CHW'(c);
                mx      = map_coord(cur_x[c], map_size[c*2 +: 2], wrap_en[c]);
                my      = map_coord(cur_y[c], map_size[c*2 +: 2], wrap_en[c]);
                res_x   = mx[OUT_W-1:0];
                res_y   = my[OUT_W-1:0];
                res_ovf = mx[OUT_W] | my[OUT_W];
`ifdef BG_AFFINE_MOSAIC_EN
                if (hc[c] != 4'd0) begin
                    res_x   = hold_x[c];
                    res_y   = hold_y[c];
                    res_ovf = hold_ovf[c];
                end
`endif
            end
        end
    end

    // Next row reference and the value the accumulator restarts from.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_x[c] = pend[c] ? ref_x[c*COORD_W +: COORD_W]
                               : int_x[c] + sext16(pb[c*16 +: 16]);
            nxt_y[c] = pend[c] ? ref_y[c*COORD_W +: COORD_W]
                               : int_y[c] + sext16(pd[c*16 +: 16]);
`ifdef BG_AFFINE_MOSAIC_EN
            vc_nxt[c] = (vc[c] >= mos_v) ? 4'd0 : vc[c] + 4'd1;
            rld_x[c]  = (vc_nxt[c] == 4'd0) ? nxt_x[c] : base_x[c];
            rld_y[c]  = (vc_nxt[c] == 4'd0) ? nxt_y[c] : base_y[c];
`else
            rld_x[c]  = nxt_x[c];
            rld_y[c]  = nxt_y[c];
`endif
        end
    end

    // Reference, accumulator and pending-reload state per channel.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int_x[c] <= '0;
                int_y[c] <= '0;
                cur_x[c] <= '0;
                cur_y[c] <= '0;
            end
            pend <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (frame_start) begin
                    int_x[c] <= ref_x[c*COORD_W +: COORD_W];
                    int_y[c] <= ref_y[c*COORD_W +: COORD_W];
                    cur_x[c] <= ref_x[c*COORD_W +: COORD_W];
                    cur_y[c] <= ref_y[c*COORD_W +: COORD_W];
                    pend[c]  <= 1'b0;
                end else if (row_start) begin
                    int_x[c] <= nxt_x[c];
                    int_y[c] <= nxt_y[c];
                    cur_x[c] <= rld_x[c];
                    cur_y[c] <= rld_y[c];
                    pend[c]  <= ref_wr[c];
                end else begin
                    if (ref_wr[c]) begin
                        pend[c] <= 1'b1;
                    end
                    if (hit && sel == CHW'(c)) begin
                        cur_x[c] <= cur_x[c] + sext16(pa[c*16 +: 16]);
                        cur_y[c] <= cur_y[c] + sext16(pc[c*16 +: 16]);
                    end
                end
            end
        end
    end

`ifdef BG_AFFINE_MOSAIC_EN
    // Mosaic hold counters, captured coordinates and vertical row base.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hc[c]       <= '0;
                vc[c]       <= '0;
                base_x[c]   <= '0;
                base_y[c]   <= '0;
                hold_x[c]   <= '0;
                hold_y[c]   <= '0;
                hold_ovf[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hit && sel == CHW'(c) && hc[c] == 4'd0) begin
                    hold_x[c]   <= res_x;
                    hold_y[c]   <= res_y;
                    hold_ovf[c] <= res_ovf;
                end
                if (frame_start) begin
                    hc[c]     <= '0;
                    vc[c]     <= '0;
                    base_x[c] <= ref_x[c*COORD_W +: COORD_W];
                    base_y[c] <= ref_y[c*COORD_W +: COORD_W];
                end else if (row_start) begin
                    hc[c] <= '0;
                    vc[c] <= vc_nxt[c];
                    if (vc_nxt[c] == 4'd0) begin
                        base_x[c] <= nxt_x[c];
                        base_y[c] <= nxt_y[c];
                    end
                end else if (hit && sel == CHW'(c)) begin
                    hc[c] <= (hc[c] >= mos_h) ? 4'd0 : hc[c] + 4'd1;
                end
            end
        end
    end
`endif

    // Registered pixel result, one cycle after the request.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= hit;
            if (hit) begin
                out_ch  <= sel;
                out_x   <= res_x;
                out_y   <= res_y;
                out_ovf <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bg_affine_coord_engine.sv
// Scoreboard bench for bg_affine_coord_engine with hand-computed vectors.
// Mosaic vectors run when BG_AFFINE_MOSAIC_EN is defined.
module tb_bg_affine_coord_engine;

    localparam int NUM_CH = 2;
    localparam int CW     = 28;

    logic                  clock = 1'b0;
    logic                  rst_b;
    logic                  frame_start;
    logic                  row_start;
    logic [NUM_CH*CW-1:0]  ref_x;
    logic [NUM_CH*CW-1:0]  ref_y;
    logic [NUM_CH-1:0]     ref_wr;
    logic [NUM_CH*16-1:0]  pa, pb, pc, pd;
    logic [NUM_CH*2-1:0]   map_size;
    logic [NUM_CH-1:0]     wrap_en;
`ifdef BG_AFFINE_MOSAIC_EN
    logic [3:0]            mos_h;
    logic [3:0]            mos_v;
`endif
    logic                  pix_req;
    logic [0:0]            pix_ch;
    logic                  out_valid;
    logic [0:0]            out_ch;
    logic [9:0]            out_x;
    logic [9:0]            out_y;
    logic                  out_ovf;

    typedef struct {
        int ch;
        int x;
        int y;
        bit ovf;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    bg_affine_coord_engine #(
        .NUM_CH(NUM_CH), .COORD_W(CW), .FRAC_BITS(8), .OUT_W(10)
    ) dut (
        .clock(clock), .rst_b(rst_b),
        .frame_start(frame_start), .row_start(row_start),
        .ref_x(ref_x), .ref_y(ref_y), .ref_wr(ref_wr),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd),
        .map_size(map_size), .wrap_en(wrap_en),
`ifdef BG_AFFINE_MOSAIC_EN
        .mos_h(mos_h), .mos_v(mos_v),
`endif
        .pix_req(pix_req), .pix_ch(pix_ch),
        .out_valid(out_valid), .out_ch(out_ch),
        .out_x(out_x), .out_y(out_y), .out_ovf(out_ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Monitor: pop and compare whenever the DUT presents a pixel.
    always @(negedge clock) begin
        exp_t e;
        if (rst_b === 1'b1 && out_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_out: got ch=%0d x=%0d y=%0d ovf=%0d, wanted none",
                         out_ch, out_x, out_y, out_ovf);
            end else begin
                e = exp_q.pop_front();
                if (out_ch !== 1'(e.ch) || out_x !== 10'(e.x) ||
                    out_y !== 10'(e.y) || out_ovf !== e.ovf ||
                    cyc != e.cyc + 1) begin
                    $display("FAIL pixel: got ch=%0d x=%0d y=%0d ovf=%0d cyc=%0d, wanted ch=%0d x=%0d y=%0d ovf=%0d cyc=%0d",
                             out_ch, out_x, out_y, out_ovf, cyc,
                             e.ch, e.x, e.y, e.ovf, e.cyc + 1);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want)
            $display("FAIL %s: got %0d, wanted %0d", name, got, want);
        else
            passed++;
    endtask

    task automatic set_ch(input int c, input logic [CW-1:0] rx, input logic [CW-1:0] ry,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] cc, input logic [15:0] d,
                          input logic [1:0] ms, input logic we);
        ref_x[c*CW +: CW] = rx;
        ref_y[c*CW +: CW] = ry;
        pa[c*16 +: 16]    = a;
        pb[c*16 +: 16]    = b;
        pc[c*16 +: 16]    = cc;
        pd[c*16 +: 16]    = d;
        map_size[c*2 +: 2] = ms;
        wrap_en[c]        = we;
    endtask

    task automatic req(input int ch, input int ex, input int ey, input bit eo);
        exp_t e;
        e = '{ch: ch, x: ex, y: ey, ovf: eo, cyc: cyc};
        exp_q.push_back(e);
        pix_req = 1'b1;
        pix_ch  = 1'(ch);
        step();
        pix_req = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic row();
        row_start = 1'b1;
        step();
        row_start = 1'b0;
    endtask

    initial begin
        rst_b       = 1'b0;
        frame_start = 1'b0;
        row_start   = 1'b0;
        ref_x       = '0;
        ref_y       = '0;
        ref_wr      = '0;
        pa          = '0;
        pb          = '0;
        pc          = '0;
        pd          = '0;
        map_size    = '0;
        wrap_en     = '0;
        pix_req     = 1'b0;
        pix_ch      = '0;
`ifdef BG_AFFINE_MOSAIC_EN
        mos_h       = '0;
        mos_v       = '0;
`endif
        repeat (3) step();
        rst_b = 1'b1;
        @(negedge clock);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ch",    int'(out_ch),    0);
        check("rst_x",     int'(out_x),     0);
        check("rst_y",     int'(out_y),     0);
        check("rst_ovf",   int'(out_ovf),   0);
        step();

        // identity map
        set_ch(0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 2'd0, 1'b0);
        set_ch(1, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 2'd0, 1'b0);
        frame();
        req(0, 0, 0, 0);
        req(0, 1, 0, 0);
        req(0, 2, 0, 0);
        req(0, 3, 0, 0);

        // row step with pd = 1.0
        set_ch(0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 2'd0, 1'b0);
        row();
        row();
        req(0, 0, 2, 0);
        req(0, 1, 2, 0);

        // clip at 128
        set_ch(0, 28'h0007F00, 0, 16'h0100, 0, 0, 0, 2'd0, 1'b0);
        frame();
        req(0, 127, 0, 0);
        req(0, 128, 0, 1);

        // wrap at 128
        set_ch(0, 28'h0007F00, 0, 16'h0100, 0, 0, 0, 2'd0, 1'b1);
        frame();
        req(0, 127, 0, 0);
        req(0, 0, 0, 0);

        // negative coordinate under clip
        set_ch(0, 28'hFFFFF00, 0, 16'h0100, 0, 0, 0, 2'd0, 1'b0);
        frame();
        req(0, 1023, 0, 1);
        req(0, 0, 0, 0);

        // mid-frame reload of ch1
        frame();
        req(1, 0, 0, 0);
        set_ch(1, 0, 28'h0005000, 16'h0100, 0, 0, 16'h0100, 2'd0, 1'b0);
        ref_wr = 2'b10;
        step();
        ref_wr = 2'b00;
        req(1, 1, 0, 0);
        row();
        req(1, 0, 80, 0);
        row();
        req(1, 0, 81, 0);

        // frame_start + row_start + pix_req together
        set_ch(0, 0, 0, 16'h0100, 0, 0, 0, 2'd0, 1'b0);
        frame();
        req(0, 0, 0, 0);
        req(0, 1, 0, 0);
        set_ch(0, 28'h0000A00, 28'h0000300, 16'h0100, 0, 0, 0, 2'd0, 1'b0);
        frame_start = 1'b1;
        row_start   = 1'b1;
        req(0, 2, 0, 0);
        frame_start = 1'b0;
        row_start   = 1'b0;
        req(0, 10, 3, 0);
        req(0, 11, 3, 0);

        // interleaved channels back to back
        req(1, 0, 80, 0);
        req(0, 12, 3, 0);
        req(1, 1, 80, 0);

`ifdef BG_AFFINE_MOSAIC_EN
        // horizontal mosaic hold
        mos_h = 4'd2;
        set_ch(0, 0, 0, 16'h0100, 0, 0, 0, 2'd0, 1'b0);
        frame();
        req(0, 0, 0, 0);
        req(0, 0, 0, 0);
        req(0, 0, 0, 0);
        req(0, 3, 0, 0);
        req(0, 3, 0, 0);
        req(0, 3, 0, 0);
        mos_h = 4'd0;
        frame();
        req(0, 0, 0, 0);
        req(0, 1, 0, 0);
        req(0, 2, 0, 0);
`endif

        repeat (4) step();
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
